icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, one-word-per-frame instruction cache between the fetch stage's PC register and the memory controller.
//  - Fetch side: fetch presents imemaddr with imemREN. The cache answers ihit/imemload. Fetch advances the PC only on ihit.
//  - Memory side: on a miss the cache drives iREN/iaddr until the controller drops iwait, then fills the frame.
// PARAMETERS
//  SETS     16   number of frames; power of 2, >=2; IDX_W=$clog2(SETS), TAG_W=30-IDX_W
//  PC_INIT  0    reset value of the captured miss address register (debug visibility only)
// PORTS
//  CLK         in   1   system clock, rising edge
//  RST         in   1   asynchronous, active-high reset
//  imemREN     in   1   fetch requests the instruction at imemaddr
//  imemaddr    in   32  word-aligned fetch address; bits[1:0] ignored
//  flush       in   1   invalidate all frames (halt / self-modifying code)
//  ihit        out  1   imemload valid this cycle for imemaddr
//  imemload    out  32  instruction word
//  iREN        out  1   read request to memory controller
//  iaddr       out  32  word address of the pending fill
//  iwait       in   1   controller busy; fill data is valid in the cycle iwait==0 while iREN==1
//  iload       in   32  fill data
// BEHAVIOUR
//  - Address split: tag=addr[31:IDX_W+2], idx=addr[IDX_W+1:2].
//  - Frame contents: valid, tag, data. Stored in the package type icache_frame_t.
//  - Reset (async, RST=1):
//    - all valid bits = 0; state = IDLE; miss_addr = PC_INIT.
//    - outputs: ihit=0, iREN=0, iaddr=PC_INIT, imemload=0.
//  - FSM states: IDLE, MISS.
//  - IDLE:
//    - hit = imemREN & valid[idx] & tag match & !flush.
//    - ihit = hit, combinational (0-cycle hit latency); imemload = data[idx].
//    - On imemREN & !hit & !flush: capture miss_addr = {imemaddr[31:2],2'b00}; go to MISS next edge.
//    - flush in IDLE: all valid = 0 next edge; ihit forced 0 that cycle; no miss launched that cycle.
//  - MISS:
//    - iREN=1, iaddr=miss_addr, ihit=0.
//    - Hold while iwait=1.
//    - When iwait=0: write frame[miss_addr idx] = {1, tag, iload}; return to IDLE.
//    - The hit is reported from the frame on the next cycle, so miss latency = memory latency + 1 cycle.
//    - imemaddr/imemREN changes during MISS are ignored; the fill always completes to miss_addr.
//    - flush during MISS: latched in flush_pend. On fill completion the fill is discarded, all valid = 0, flush_pend = 0, IDLE.
//  - Outside MISS: iREN=0 and iaddr holds miss_addr.
//  - imemload = 0 whenever ihit=0, to keep traces clean.
//  - Reset mid-MISS: iREN drops immediately (async). The controller tolerates request withdrawal.
//  - Simultaneous write and read of the same idx cannot occur: reads only hit in IDLE, writes only happen in MISS.
// CONFIGURATION
//  ICACHE_STATS_EN defined adds ports:
//    - hit_cnt out 32: +1 per cycle with ihit=1.
//    - miss_cnt out 32: +1 per IDLE->MISS transition.
//    - Both saturate at 32'hFFFF_FFFF, clear on RST, and are not cleared by flush.
//  ICACHE_STATS_EN undefined: ports absent, no counter logic.
// STRUCTURE
//  cpu_types_pkg (shared package) adds:
//    - icache_frame_t struct {logic valid; logic [TAG_W-1:0] tag; word_t data;}
//    - icache_state_t enum {IDLE, MISS}
//    - ICACHE_SETS=16 localparam
//  Sub-module: icache_frame_array holds the SETS frames. Ports: CLK, RST, flush_all, wen, widx, wframe, ridx, rframe.
//  Top level holds the FSM, hit compare, miss_addr/flush_pend and the stats counters.
// TESTING
//  1. Cold miss: RST pulse, imemREN=1, imemaddr=0x0.
//     -> iREN=1, iaddr=0x0 next cycle.
//     -> iwait=1 for 3 cycles, then iwait=0 with iload=0x2001_0004.
//     -> ihit=1, imemload=0x2001_0004 the following cycle.
//  2. Conflict (SETS=16): fill 0x0, then request 0x40 (same idx 0, different tag).
//     -> miss, iaddr=0x40.
//     -> after fill, 0x0 misses again.
//  3. Hit stream: prefill 0x0..0x3C, sweep imemaddr 0x0..0x3C by 4 per cycle.
//     -> ihit=1 every cycle, iREN never asserts.
//  4. Flush mid-miss: miss on 0x8, assert flush for 1 cycle while iwait=1, complete the fill.
//     -> state IDLE, 0x8 and all previously valid addresses miss.
//  5. Reset mid-miss: RST during MISS with iwait=1.
//     -> iREN=0 immediately, no frame written, 0x8 still misses after release.
//  6. Stats (ICACHE_STATS_EN): run test 3 after a cold prefill.
//     -> miss_cnt=16, hit_cnt=16.
//     -> counter forced to 32'hFFFF_FFFF stays there on a further hit.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the instruction cache frame and FSM state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;
    typedef struct packed {
        logic valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t data;
    } icache_frame_t;
    typedef enum logic {IDLE, MISS} icache_state_t;
endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: SETS frames with async-cleared valid bits and a single-cycle bulk invalidate.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush_all,
    input  logic             wen,
    input  logic [IDX_W-1:0] widx,
    input  icache_frame_t    wframe,
    input  logic [IDX_W-1:0] ridx,
    output icache_frame_t    rframe
);
    logic [SETS-1:0] valid;
    logic [ICACHE_TAG_W-1:0] tags [SETS];
    word_t datas [SETS];

    // Only the valid bits need reset; tag/data are ignored until a fill sets valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            valid <= '0;
        else if (flush_all)
            valid <= '0;
        else if (wen)
            valid[widx] <= wframe.valid;
    end

    always_ff @(posedge CLK) begin
        if (wen && !flush_all) begin
            tags[widx] <= wframe.tag;
            datas[widx] <= wframe.data;
        end
    end

    always_comb begin
        rframe = '{valid: valid[ridx], tag: tags[ridx], data: datas[ridx]};
    end
endmodule

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped one-word-per-frame I-cache with 0-cycle hits and a fill FSM.
// Optional ICACHE_STATS_EN adds saturating hit_cnt/miss_cnt ports.
module icache_direct_mapped
    import cpu_types_pkg::*;
#(
    parameter int          SETS    = ICACHE_SETS,
    parameter logic [31:0] PC_INIT = '0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    // Frame tags are sized for the package default; fewer sets would need wider tags.
    if (TAG_W > ICACHE_TAG_W) begin : g_bad_sets
        $error("icache_direct_mapped: SETS too small for icache_frame_t tag width");
    end

    icache_state_t state;
    logic [31:0] miss_addr;
    logic flush_pend;
    logic [IDX_W-1:0] ridx, widx;
    logic [TAG_W-1:0] rtag;
    icache_frame_t rframe, wframe;
    logic hit, miss_launch, fill_done, wen, flush_all;
    logic unused_bits;

    assign ridx = imemaddr[IDX_W+1:2];
    assign rtag = imemaddr[31:IDX_W+2];
    assign widx = miss_addr[IDX_W+1:2];
    assign unused_bits = ^{imemaddr[1:0], miss_addr[1:0]};

    assign hit = state == IDLE && imemREN && !flush && rframe.valid && rframe.tag == ICACHE_TAG_W'(rtag);
    assign ihit = hit;
    assign imemload = hit ? rframe.data : '0;
    assign miss_launch = state == IDLE && imemREN && !flush && !hit;
    assign fill_done = state == MISS && !iwait;
    // A flush seen at any point of the miss (including its last cycle) discards the fill.
    assign wen = fill_done && !flush_pend && !flush;
    assign flush_all = (state == IDLE && flush) || (fill_done && (flush_pend || flush));
    assign wframe = '{valid: 1'b1, tag: ICACHE_TAG_W'(miss_addr[31:IDX_W+2]), data: iload};
    assign iaddr = miss_addr;

    icache_frame_array #(.SETS(SETS)) u_frames (
        .CLK(CLK),
        .RST(RST),
        .flush_all(flush_all),
        .wen(wen),
        .widx(widx),
        .wframe(wframe),
        .ridx(ridx),
        .rframe(rframe)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            miss_addr <= PC_INIT;
            flush_pend <= 1'b0;
            iREN <= 1'b0;
        end else if (state == IDLE) begin
            if (miss_launch) begin
                state <= MISS;
                miss_addr <= {imemaddr[31:2], 2'b00};
                iREN <= 1'b1;
            end
        end else if (!iwait) begin
            state <= IDLE;
            flush_pend <= 1'b0;
            iREN <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (ihit && !(&hit_cnt))
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_launch && !(&miss_cnt))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: directed checks of hits, misses, conflicts, flush and reset behaviour.
module tb_icache_direct_mapped;
    logic CLK = 1'b0;
    logic RST, imemREN, flush, iwait;
    logic [31:0] imemaddr, iload;
    logic ihit, iREN;
    logic [31:0] imemload, iaddr;
    int vectors = 0;
    int miscompares = 0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 CLK = ~CLK;

    icache_direct_mapped dut (
        .CLK(CLK),
        .RST(RST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .flush(flush),
        .ihit(ihit),
        .imemload(imemload),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        @(negedge CLK);
        iwait = 1'b0; iload = d;
        @(negedge CLK);
        imemREN = 1'b0; iwait = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1; imemREN = 1'b0; flush = 1'b0; iwait = 1'b1; iload = '0; imemaddr = '0;
        repeat (2) @(negedge CLK);
        vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL reset_ihit: got %b want 0", ihit); end
        vectors++; if (iREN !== 1'b0) begin miscompares++; $display("FAIL reset_iREN: got %b want 0", iREN); end
        vectors++; if (iaddr !== 32'h0) begin miscompares++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
        vectors++; if (imemload !== 32'h0) begin miscompares++; $display("FAIL reset_imemload: got %h want 0", imemload); end
        RST = 1'b0;
    endtask

    task automatic test_cold_miss;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0;
        #1;
        vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL cold_ihit0: got %b want 0", ihit); end
        @(negedge CLK);
        vectors++; if (iREN !== 1'b1) begin miscompares++; $display("FAIL cold_iREN: got %b want 1", iREN); end
        vectors++; if (iaddr !== 32'h0) begin miscompares++; $display("FAIL cold_iaddr: got %h want 0", iaddr); end
        repeat (2) @(negedge CLK);
        vectors++; if (iREN !== 1'b1 || ihit !== 1'b0) begin miscompares++; $display("FAIL cold_hold: got iREN=%b ihit=%b want 1/0", iREN, ihit); end
        iwait = 1'b0; iload = 32'h2001_0004;
        @(negedge CLK);
        iwait = 1'b1;
        vectors++; if (ihit !== 1'b1) begin miscompares++; $display("FAIL cold_hit: got %b want 1", ihit); end
        vectors++; if (imemload !== 32'h2001_0004) begin miscompares++; $display("FAIL cold_data: got %h want 20010004", imemload); end
        vectors++; if (iREN !== 1'b0) begin miscompares++; $display("FAIL cold_iREN_drop: got %b want 0", iREN); end
        imemREN = 1'b0;
    endtask

    task automatic test_conflict;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h40;
        #1;
        vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL conflict_miss40: got %b want 0", ihit); end
        @(negedge CLK);
        vectors++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin miscompares++; $display("FAIL conflict_req40: got iREN=%b iaddr=%h want 1/00000040", iREN, iaddr); end
        iwait = 1'b0; iload = 32'hCAFE_0040;
        @(negedge CLK);
        iwait = 1'b1;
        vectors++; if (ihit !== 1'b1 || imemload !== 32'hCAFE_0040) begin miscompares++; $display("FAIL conflict_hit40: got ihit=%b data=%h want 1/cafe0040", ihit, imemload); end
        imemaddr = 32'h0;
        #1;
        vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL conflict_evict0: got %b want 0", ihit); end
        @(negedge CLK);
        vectors++; if (iREN !== 1'b1 || iaddr !== 32'h0) begin miscompares++; $display("FAIL conflict_req0: got iREN=%b iaddr=%h want 1/00000000", iREN, iaddr); end
        iwait = 1'b0; iload = 32'h2001_0004;
        @(negedge CLK);
        iwait = 1'b1;
        vectors++; if (ihit !== 1'b1 || imemload !== 32'h2001_0004) begin miscompares++; $display("FAIL conflict_hit0: got ihit=%b data=%h want 1/20010004", ihit, imemload); end
        imemREN = 1'b0;
    endtask

    task automatic test_flush_idle;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0;
        #1;
        vectors++; if (ihit !== 1'b1) begin miscompares++; $display("FAIL flush_idle_prehit: got %b want 1", ihit); end
        flush = 1'b1;
        #1;
        vectors++; if (ihit !== 1'b0 || imemload !== 32'h0) begin miscompares++; $display("FAIL flush_idle_mask: got ihit=%b data=%h want 0/0", ihit, imemload); end
        @(negedge CLK);
        flush = 1'b0;
        #1;
        vectors++; if (iREN !== 1'b0) begin miscompares++; $display("FAIL flush_idle_nomiss: got iREN=%b want 0", iREN); end
        vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL flush_idle_invalid: got %b want 0", ihit); end
        imemREN = 1'b0;
    endtask

    task automatic prefill;
        for (int i = 0; i < 16; i++) fill(32'(i * 4), 32'h1000_0000 + 32'(i));
    endtask

    task automatic test_hit_stream;
        prefill();
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            imemREN = 1'b1; imemaddr = 32'(i * 4);
            #1;
            vectors++; if (ihit !== 1'b1) begin miscompares++; $display("FAIL stream_hit[%0d]: got %b want 1", i, ihit); end
            vectors++; if (imemload !== 32'h1000_0000 + 32'(i)) begin miscompares++; $display("FAIL stream_data[%0d]: got %h want %h", i, imemload, 32'h1000_0000 + 32'(i)); end
            vectors++; if (iREN !== 1'b0) begin miscompares++; $display("FAIL stream_iREN[%0d]: got %b want 0", i, iREN); end
        end
        @(negedge CLK);
        imemREN = 1'b0;
    endtask

    task automatic test_flush_mid_miss;
        logic [31:0] probe [4] = '{32'h8, 32'h0, 32'h3C, 32'h48};
        fill(32'h48, 32'h2000_0048);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h8;
        #1;
        vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL fmiss_miss8: got %b want 0", ihit); end
        @(negedge CLK);
        vectors++; if (iREN !== 1'b1 || iaddr !== 32'h8) begin miscompares++; $display("FAIL fmiss_req: got iREN=%b iaddr=%h want 1/00000008", iREN, iaddr); end
        flush = 1'b1; imemaddr = 32'h30;
        @(negedge CLK);
        flush = 1'b0;
        vectors++; if (iREN !== 1'b1 || iaddr !== 32'h8) begin miscompares++; $display("FAIL fmiss_hold: got iREN=%b iaddr=%h want 1/00000008", iREN, iaddr); end
        iwait = 1'b0; iload = 32'hDEAD_0008;
        @(negedge CLK);
        iwait = 1'b1;
        vectors++; if (iREN !== 1'b0) begin miscompares++; $display("FAIL fmiss_idle: got iREN=%b want 0", iREN); end
        for (int i = 0; i < 4; i++) begin
            imemaddr = probe[i];
            #1;
            vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL fmiss_invalid[%h]: got %b want 0", probe[i], ihit); end
        end
        imemREN = 1'b0;
    endtask

    task automatic test_reset_mid_miss;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h8;
        @(negedge CLK);
        vectors++; if (iREN !== 1'b1) begin miscompares++; $display("FAIL rmiss_req: got iREN=%b want 1", iREN); end
        #1 RST = 1'b1;
        #1;
        vectors++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin miscompares++; $display("FAIL rmiss_async: got iREN=%b iaddr=%h want 0/00000000", iREN, iaddr); end
        iwait = 1'b0; iload = 32'hBAD0_0008;
        @(negedge CLK);
        RST = 1'b0; iwait = 1'b1;
        #1;
        vectors++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL rmiss_nowrite: got ihit=%b want 0", ihit); end
        imemREN = 1'b0;
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        vectors++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin miscompares++; $display("FAIL stats_reset: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
        prefill();
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            imemREN = 1'b1; imemaddr = 32'(i * 4);
        end
        @(negedge CLK);
        imemREN = 1'b0;
        vectors++; if (miss_cnt !== 32'd16) begin miscompares++; $display("FAIL stats_miss: got %0d want 16", miss_cnt); end
        vectors++; if (hit_cnt !== 32'd16) begin miscompares++; $display("FAIL stats_hit: got %0d want 16", hit_cnt); end
        force dut.hit_cnt = 32'hFFFF_FFFF;
        @(negedge CLK);
        release dut.hit_cnt;
        imemREN = 1'b1; imemaddr = 32'h0;
        @(negedge CLK);
        imemREN = 1'b0;
        vectors++; if (hit_cnt !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL stats_sat: got %h want ffffffff", hit_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_flush_idle();
        test_hit_stream();
        test_flush_mid_miss();
        test_reset_mid_miss();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
